// File: rtl/b_muxn_rr.sv
// N-channel streaming multiplexer with valid/ready on every port, one registered
// output stage, and either external (fixed) or round-robin channel selection.
module b_muxn_rr #(
  parameter int W    = 8,
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  i,
  input  logic [N-1:0]    i_valid,
  output logic [N-1:0]    i_ready,
  input  logic            mode,
  input  logic [SELW-1:0] s,
  output logic [W-1:0]    y,
  output logic            y_valid,
  input  logic            y_ready,
  output logic [SELW-1:0] y_ch
);

  logic            load;
  logic            grant_ok;
  logic [SELW-1:0] grant;
  logic [SELW-1:0] ptr;
  logic [W-1:0]    grant_data;
  int              best_d;
  int              d;

  // The output slot is free when empty or being drained this cycle.
  assign load = !y_valid || y_ready;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    grant_ok = 1'b0;
    grant    = '0;
    best_d   = N;
    d        = 0;
    if (!mode) begin
      for (int k = 0; k < N; k++) begin
        if (int'(s) == k && i_valid[k]) begin
          grant_ok = 1'b1;
          grant    = SELW'(k);
        end
      end
    end else begin
      // Rotational distance from the slot after ptr; the nearest valid wins.
      for (int k = 0; k < N; k++) begin
        d = (k + 2 * N - 1 - int'(ptr)) % N;
        if (i_valid[k] && d < best_d) begin
          best_d   = d;
          grant_ok = 1'b1;
          grant    = SELW'(k);
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    i_ready    = '0;
    for (int k = 0; k < N; k++) begin
      if (grant == SELW'(k)) begin
        grant_data = i[k*W +: W];
      end
      i_ready[k] = !rst && load && grant_ok && (grant == SELW'(k));
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      y       <= '0;
      y_valid <= 1'b0;
      y_ch    <= '0;
      ptr     <= SELW'(N - 1);
    end else if (load) begin
      if (grant_ok) begin
        y       <= grant_data;
        y_ch    <= grant;
        y_valid <= 1'b1;
        ptr     <= grant;
      end else begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule
